mem_line_adapter: RTL and testbench
===================================

MEM_LINE_ADAPTER -- requirements
Module: mem_line_adapter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 28, word address width; WORD_WIDTH, default 32, word bus data width; LINE_WIDTH, default 256, cache line width; BEATS = LINE_WIDTH/WORD_WIDTH, fixed at 8.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_addr  input  28  line request word address from the D-cache controller; bits [2:0] ignored.
REQ-005 mem_wr  input  256  write line; word j occupies bits [32j+31:32j].
REQ-006 mem_rw  input  1  1 = write line, 0 = read line.
REQ-007 mem_valid  input  1  line request, held high until mem_ready.
REQ-008 mem_rd  output  256  read line returned to the cache.
REQ-009 mem_ready  output  1  single-cycle line completion pulse.
REQ-010 w_addr  output  28  word bus address.
REQ-011 w_wdata  output  32  word bus write data.
REQ-012 w_rw  output  1  word bus direction, 1 = write.
REQ-013 w_valid  output  1  word bus request.
REQ-014 w_rdata  input  32  word bus read data, valid when w_ready is high.
REQ-015 w_ready  input  1  word bus beat completion; may arrive in the same cycle w_valid rises.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BEAT and RESP.
REQ-017 In IDLE with mem_valid=1, the block SHALL accept on the next edge:
  - latch mem_addr[27:3], mem_rw and mem_wr;
  - clear beat counter to 0;
  - go to BEAT.
REQ-018 In BEAT, w_valid SHALL be 1.
REQ-019 In BEAT, w_addr SHALL equal {latched addr[27:3], beat[2:0]}.
REQ-020 In BEAT, w_rw SHALL equal the latched rw.
REQ-021 In BEAT, w_wdata SHALL equal latched line word [beat]; it SHALL be 0 on reads.
REQ-022 In BEAT, w_addr, w_rw and w_wdata SHALL stay stable until w_ready.
REQ-023 On a w_ready edge during a read, w_rdata SHALL be written into line buffer word [beat].
REQ-024 On each w_ready edge with beat<7, beat SHALL increment.
REQ-025 On a w_ready edge with beat==7, the FSM SHALL go to RESP; beat SHALL NOT wrap to 0 inside BEAT.
REQ-026 RESP SHALL last one cycle, assert mem_ready=1, then return to IDLE.
REQ-027 mem_rd SHALL equal the line buffer continuously.
  - Content is valid from the RESP cycle until the next read accept.
  - A write transaction SHALL NOT modify the line buffer.
REQ-028 Latency with w_ready tied high: accept edge at cycle N; beats in cycles N+1..N+8; mem_ready in cycle N+9.
REQ-029 mem_ready SHALL be 0 in every state other than RESP.
REQ-030 w_valid SHALL be 0 in IDLE and RESP.
REQ-031 A request SHALL NOT be re-accepted in the RESP cycle.
  - If mem_valid is still high in the following IDLE cycle, it SHALL be treated as a new request.
  - This covers back-to-back flush write-backs and write-back followed by allocate.
REQ-032 Abort: if mem_valid falls during BEAT, the current beat SHALL complete its w_ready handshake.
  - The FSM SHALL then return to IDLE with no mem_ready pulse.
  - mem_rd content after an abort is undefined.
REQ-033 A change of mem_addr, mem_rw or mem_wr after accept SHALL have no effect on the transaction in progress.

Reset
REQ-034 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and beat and the line buffer SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abandon it immediately, even if a w_ready handshake is outstanding.
REQ-036 The first request after reset deassertion SHALL be accepted normally.

Structure
REQ-037 A shared package, cache_pkg, SHALL hold: ADDR_WIDTH, WORD_WIDTH, LINE_WIDTH, BEATS and the state encodings (IDLE=2'b00, BEAT=2'b01, RESP=2'b10).
REQ-038 The block SHALL be a single module with no sub-modules; the line buffer is a plain register array.

Verification
REQ-039 Read line: request mem_addr=28'h0001238, rw=0, memory model returns word = address, w_ready always 1.
  - w_addr SHALL be 28'h0001238..28'h000123F.
  - mem_ready SHALL pulse in cycle N+9.
  - mem_rd word j SHALL equal 28'h0001238+j.
REQ-040 Write line: mem_wr word j = 32'hA5A5_0000+j, rw=1, w_ready delayed 2 cycles per beat.
  - Eight writes SHALL carry the correct data.
  - Each beat SHALL hold for 3 cycles.
  - mem_ready SHALL pulse exactly once.
REQ-041 Back-to-back: mem_valid held high, mem_addr stepped by 8 after each mem_ready (flush pattern).
  - Each line SHALL start the cycle after RESP plus one IDLE cycle.
  - There SHALL be no duplicate lines and no skipped lines.
REQ-042 Abort: drop mem_valid at beat 3 with w_ready delayed 1 cycle.
  - Beat 3 SHALL complete.
  - The FSM SHALL return to IDLE with no mem_ready and no further w_valid.
REQ-043 Reset mid-beat: assert rst_n=0 at beat 5.
  - All outputs SHALL be 0 immediately.
  - A subsequent read SHALL complete correctly from beat 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared sizes and FSM encodings for the cache memory-side line adapter.
package cache_pkg;

  localparam int ADDR_WIDTH = 28;
  localparam int WORD_WIDTH = 32;
  localparam int LINE_WIDTH = 256;
  localparam int BEATS      = LINE_WIDTH / WORD_WIDTH;
  localparam int BEAT_BITS  = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BEAT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/mem_line_adapter.sv
// Splits cache line read/write requests into eight word-bus beats.
// state | meaning: IDLE wait for mem_valid | BEAT word transfer [beat] | RESP one-cycle mem_ready
module mem_line_adapter #(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
  parameter int WORD_WIDTH = cache_pkg::WORD_WIDTH,
  parameter int LINE_WIDTH = cache_pkg::LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [LINE_WIDTH-1:0] mem_wr,
  input  logic                  mem_rw,
  input  logic                  mem_valid,
  output logic [LINE_WIDTH-1:0] mem_rd,
  output logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [WORD_WIDTH-1:0] w_wdata,
  output logic                  w_rw,
  output logic                  w_valid,
  input  logic [WORD_WIDTH-1:0] w_rdata,
  input  logic                  w_ready
);
  import cache_pkg::*;

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  state_t                         state_q, state_d;
  logic [BEAT_BITS-1:0]           beat_q;
  logic [ADDR_WIDTH-BEAT_BITS-1:0] line_addr_q;
  logic                           rw_q;
  logic                           abort_q;
  logic [WORD_WIDTH-1:0]          wr_q   [BEATS];
  logic [WORD_WIDTH-1:0]          line_q [BEATS];
  logic                           beat_done;
  logic                           last_beat;
  logic                           addr_lsb_unused;

  assign beat_done       = (state_q == BEAT) && w_ready;
  assign last_beat       = (beat_q == LAST_BEAT);
  assign addr_lsb_unused = ^mem_addr[BEAT_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // An abort only takes effect once the outstanding beat has handshaken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_valid) state_d = BEAT;
      BEAT: begin
        if (w_ready) begin
          if (abort_q || !mem_valid) state_d = IDLE;
          else if (last_beat)        state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      line_addr_q <= '0;
      rw_q        <= 1'b0;
      abort_q     <= 1'b0;
      for (int j = 0; j < BEATS; j++) begin
        wr_q[j]   <= '0;
        line_q[j] <= '0;
      end
    end else begin
      if (state_q == IDLE && mem_valid) begin
        line_addr_q <= mem_addr[ADDR_WIDTH-1:BEAT_BITS];
        rw_q        <= mem_rw;
        beat_q      <= '0;
        abort_q     <= 1'b0;
        for (int j = 0; j < BEATS; j++) wr_q[j] <= mem_wr[j*WORD_WIDTH +: WORD_WIDTH];
      end
      if (state_q == BEAT && !mem_valid) abort_q <= 1'b1;
      if (beat_done) begin
        if (!rw_q)      line_q[beat_q] <= w_rdata;
        if (!last_beat) beat_q <= beat_q + BEAT_BITS'(1);
      end
    end
  end

  always_comb begin
    w_valid   = 1'b0;
    w_addr    = '0;
    w_rw      = 1'b0;
    w_wdata   = '0;
    mem_ready = 1'b0;
    unique case (state_q)
      BEAT: begin
        w_valid = 1'b1;
        w_addr  = {line_addr_q, beat_q};
        w_rw    = rw_q;
        w_wdata = rw_q ? wr_q[beat_q] : '0;
      end
      RESP:    mem_ready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mem_rd = '0;
    for (int j = 0; j < BEATS; j++) mem_rd[j*WORD_WIDTH +: WORD_WIDTH] = line_q[j];
  end

endmodule

// File: tb/tb_mem_line_adapter.sv
// Directed + randomized bench for mem_line_adapter against a word-addressed memory model.
module tb_mem_line_adapter;
  localparam int AW = 28, WW = 32, LW = 256, NB = 8;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [AW-1:0] mem_addr = '0;
  logic [LW-1:0] mem_wr = '0;
  logic          mem_rw = 1'b0, mem_valid = 1'b0;
  logic [LW-1:0] mem_rd;
  logic          mem_ready;
  logic [AW-1:0] w_addr;
  logic [WW-1:0] w_wdata;
  logic          w_rw, w_valid;
  logic [WW-1:0] w_rdata = '0;
  logic          w_ready = 1'b0;

  mem_line_adapter dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rw(mem_rw),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_ready(mem_ready), .w_addr(w_addr),
    .w_wdata(w_wdata), .w_rw(w_rw), .w_valid(w_valid), .w_rdata(w_rdata), .w_ready(w_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic rw; logic [WW-1:0] data; } beat_t;
  beat_t         beat_log[$];
  logic [WW-1:0] slave_mem [65536];
  bit            written   [65536];
  logic [WW-1:0] ref_mem   [65536];
  bit            ref_written [65536];

  int cyc = 0, lat = 0, wait_cnt = 0, ready_cnt = 0, ready_cyc = 0, stab_err = 0;
  int tests = 0, fails = 0;
  logic          p_pending = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic          p_rw = 1'b0;
  logic [WW-1:0] p_wdata = '0;
  logic [LW-1:0] model_rd = '0;
  bit            model_known = 1'b1;

  function automatic logic [WW-1:0] slave_val(input logic [AW-1:0] a);
    if (written[a[15:0]]) return slave_mem[a[15:0]];
    return WW'(a);
  endfunction

  function automatic logic [WW-1:0] ref_val(input logic [AW-1:0] a);
    if (ref_written[a[15:0]]) return ref_mem[a[15:0]];
    return WW'(a);
  endfunction

  // Word-bus slave: answers after `lat` wait cycles, memory defaults to word = address.
  always @(negedge clk) begin
    w_ready = w_valid && (wait_cnt >= lat);
    w_rdata = (w_ready && !w_rw) ? slave_val(w_addr) : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 0;
      p_pending <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (w_valid && w_ready) begin
        beat_log.push_back('{w_addr, w_rw, w_wdata});
        if (w_rw) begin
          slave_mem[w_addr[15:0]] <= w_wdata;
          written[w_addr[15:0]]   <= 1'b1;
        end
        wait_cnt <= 0;
      end else if (w_valid) begin
        wait_cnt <= wait_cnt + 1;
      end
      if (p_pending && ({w_valid, w_addr, w_rw, w_wdata} !== {1'b1, p_addr, p_rw, p_wdata}))
        stab_err <= stab_err + 1;
      p_pending <= w_valid && !w_ready;
      p_addr    <= w_addr;
      p_rw      <= w_rw;
      p_wdata   <= w_wdata;
      if (mem_ready) begin
        ready_cnt <= ready_cnt + 1;
        ready_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int j = 0; j < NB; j++) l[j*WW +: WW] = $urandom;
    return l;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check(tag, LW'({mem_ready, w_valid, w_rw, w_addr, w_wdata}), '0);
  endtask

  // One line transaction; expectations come from the line-level memory model.
  task automatic run_line(input string tag, input logic [AW-1:0] addr, input logic rw,
                          input logic [LW-1:0] line, input int l, input bit scramble);
    int acc, rc0, n0, t;
    logic [AW-1:0] base;
    logic [LW-1:0] exp_rd;
    beat_t e;
    lat  = l;
    base = {addr[AW-1:3], 3'b000};
    n0   = beat_log.size();
    rc0  = ready_cnt;
    for (int j = 0; j < NB; j++) exp_rd[j*WW +: WW] = ref_val(base + AW'(j));
    mem_addr = addr; mem_rw = rw; mem_wr = line; mem_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    if (scramble) begin
      mem_addr = AW'($urandom); mem_rw = ~rw; mem_wr = rand_line();
    end
    t = 0;
    while (mem_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    check({tag, "_timeout"}, LW'(t < 300), LW'(1));
    mem_valid = 1'b0;
    @(negedge clk);
    check({tag, "_latency"}, LW'(ready_cyc - acc), LW'(NB * (l + 1) + 1));
    check({tag, "_ready_count"}, LW'(ready_cnt - rc0), LW'(1));
    check({tag, "_beats"}, LW'(beat_log.size() - n0), LW'(NB));
    for (int j = 0; j < NB; j++) begin
      if (beat_log.size() > n0 + j) begin
        e = beat_log[n0 + j];
        check({tag, "_beat"}, LW'({e.addr, e.rw, e.data}),
              LW'({base + AW'(j), rw, rw ? line[j*WW +: WW] : WW'(0)}));
      end
    end
    if (rw) begin
      for (int j = 0; j < NB; j++) begin
        ref_mem[base[15:0] + 16'(j)]     = line[j*WW +: WW];
        ref_written[base[15:0] + 16'(j)] = 1'b1;
      end
    end else begin
      model_rd    = exp_rd;
      model_known = 1'b1;
    end
    if (model_known) check({tag, "_mem_rd"}, mem_rd, model_rd);
    check_idle_outputs({tag, "_idle_after"});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t, n0, rc0, acc;
    int rcs [4];
    logic [LW-1:0] lines [4];
    logic [LW-1:0] wline;
    logic [AW-1:0] base;
    beat_t e;

    #1 rst_n = 1'b0;
    #2;
    check_idle_outputs("reset_outputs");
    check("reset_mem_rd", mem_rd, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read line: memory returns word = address, w_ready tied high.
    run_line("read_1238", 28'h0001238, 1'b0, '0, 0, 1'b0);
    check("read_1238_word7", LW'(mem_rd[7*WW +: WW]), LW'(32'h0000123F));

    // Write line with two wait cycles per beat.
    for (int j = 0; j < NB; j++) wline[j*WW +: WW] = 32'hA5A5_0000 + 32'(j);
    run_line("write_a5a5", 28'h0002000, 1'b1, wline, 2, 1'b0);
    run_line("readback_a5a5", 28'h0002005, 1'b0, '0, 1, 1'b0);

    // Back-to-back flush write-backs with mem_valid held high.
    lat = 0; base = 28'h0006000;
    for (int k = 0; k < 4; k++) lines[k] = rand_line();
    n0 = beat_log.size(); rc0 = ready_cnt;
    mem_rw = 1'b1; mem_addr = base; mem_wr = lines[0]; mem_valid = 1'b1;
    acc = cyc;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (mem_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      check("b2b_timeout", LW'(t < 100), LW'(1));
      if (k < 3) begin
        mem_addr = mem_addr + AW'(8);
        mem_wr   = lines[k+1];
      end else begin
        mem_valid = 1'b0;
      end
      @(negedge clk);
      rcs[k] = ready_cyc;
    end
    check("b2b_first_latency", LW'(rcs[0] - acc), LW'(9));
    for (int k = 1; k < 4; k++) check("b2b_spacing", LW'(rcs[k] - rcs[k-1]), LW'(10));
    check("b2b_ready_count", LW'(ready_cnt - rc0), LW'(4));
    check("b2b_beats", LW'(beat_log.size() - n0), LW'(32));
    for (int i = 0; i < 32; i++) begin
      if (beat_log.size() > n0 + i) begin
        e = beat_log[n0 + i];
        check("b2b_beat", LW'({e.addr, e.rw, e.data}),
              LW'({base + AW'(i), 1'b1, lines[i/8][(i%8)*WW +: WW]}));
      end
    end
    for (int i = 0; i < 32; i++) begin
      ref_mem[base[15:0] + 16'(i)]     = lines[i/8][(i%8)*WW +: WW];
      ref_written[base[15:0] + 16'(i)] = 1'b1;
    end
    run_line("b2b_readback", 28'h0006010, 1'b0, '0, 0, 1'b0);

    // Abort: drop mem_valid at the start of beat 3, one wait cycle per beat.
    lat = 1; base = 28'h0001238 & ~28'h7;
    n0 = beat_log.size(); rc0 = ready_cnt;
    mem_rw = 1'b0; mem_addr = 28'h0001238; mem_valid = 1'b1;
    t = 0;
    while (!(w_valid && w_addr[2:0] == 3'd3 && wait_cnt == 0) && t < 100) begin
      @(negedge clk); t++;
    end
    check("abort_reach_beat3", LW'(t < 100), LW'(1));
    mem_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_beats", LW'(beat_log.size() - n0), LW'(4));
    if (beat_log.size() > n0) check("abort_last_beat", LW'(beat_log[$].addr), LW'(base + AW'(3)));
    check("abort_no_ready", LW'(ready_cnt - rc0), LW'(0));
    check_idle_outputs("abort_idle");
    model_known = 1'b0;

    // Reset in the middle of beat 5.
    lat = 1;
    mem_rw = 1'b0; mem_addr = 28'h0002000; mem_valid = 1'b1;
    t = 0;
    while (!(w_valid && w_addr[2:0] == 3'd5) && t < 100) begin @(negedge clk); t++; end
    check("reset_reach_beat5", LW'(t < 100), LW'(1));
    rst_n = 1'b0;
    mem_valid = 1'b0;
    #1;
    check_idle_outputs("midreset_outputs");
    check("midreset_mem_rd", mem_rd, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rd = '0; model_known = 1'b1;
    @(negedge clk);
    run_line("after_reset_read", 28'h0002003, 1'b0, '0, 0, 1'b0);

    // Randomized reads/writes over a small region, with input scrambling after accept.
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] a;
      a = 28'h0004000 + AW'($urandom_range(0, 15) * 8) + AW'($urandom_range(0, 7));
      run_line("rand", a, 1'($urandom_range(0, 1)), rand_line(),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check("handshake_stability", LW'(stab_err), LW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
